// File: rtl/uarc_send_arbiter_if.sv
// Bus bundle for uarc_send_arbiter: per-requester send/data/ack lanes plus the
// single shared receiver lane. master = sender side + receiver, slave = arbiter.
interface uarc_send_arbiter_if #(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned REQUESTERS = 4
);
  localparam int unsigned IDX_WIDTH = $clog2(REQUESTERS);

  logic [REQUESTERS-1:0]            req_sends;
  logic [REQUESTERS*WORD_WIDTH-1:0] req_datas;
  logic [REQUESTERS-1:0]            req_send_acks;
  logic                             out_send;
  logic [WORD_WIDTH-1:0]            out_data;
  logic                             out_send_ack;
  logic [IDX_WIDTH-1:0]             grant_idx;

  modport master (
    output req_sends, req_datas, out_send_ack,
    input  req_send_acks, out_send, out_data, grant_idx
  );

  modport slave (
    input  req_sends, req_datas, out_send_ack,
    output req_send_acks, out_send, out_data, grant_idx
  );
endinterface

// File: rtl/uarc_send_arbiter.sv
// Non-preemptive round-robin arbiter sharing one UARC receiver send lane.
// Define UARC_ARB_PRIO0_EN to give requester 0 strict priority over a 1..N-1 ring.
module uarc_send_arbiter #(
  parameter int unsigned WORD_MAG   = 5,
  parameter int unsigned REQUESTERS = 4
) (
  input logic              clk,
  input logic              reset,
  uarc_send_arbiter_if.slave bus
);
  localparam int unsigned WORD_WIDTH = 1 << WORD_MAG;
  localparam int unsigned IDX_WIDTH  = $clog2(REQUESTERS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(REQUESTERS - 1);
`ifdef UARC_ARB_PRIO0_EN
  localparam logic [IDX_WIDTH-1:0] PTR_RST = IDX_WIDTH'(1);
`else
  localparam logic [IDX_WIDTH-1:0] PTR_RST = '0;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                  state, state_next;
  logic [WORD_WIDTH-1:0]   data_q;
  logic [IDX_WIDTH-1:0]    gidx_q;
  logic [IDX_WIDTH-1:0]    rr_ptr;
  logic [IDX_WIDTH-1:0]    rr_next;
  logic [IDX_WIDTH-1:0]    search_base;
  logic [IDX_WIDTH-1:0]    pick;
  logic                    found;
  logic                    complete;
  logic                    load;
  logic [REQUESTERS-1:0]   gmask;
  logic [REQUESTERS-1:0]   search_reqs;

  // Reset wins over a same-cycle ack so an abandoned word is never acknowledged.
  always_comb begin
    complete = (state == BUSY) && bus.out_send_ack && !reset;
    gmask    = REQUESTERS'(1) << gidx_q;
`ifdef UARC_ARB_PRIO0_EN
    if (gidx_q == '0)
      rr_next = rr_ptr;
    else if (gidx_q == LAST_IDX)
      rr_next = IDX_WIDTH'(1);
    else
      rr_next = gidx_q + IDX_WIDTH'(1);
`else
    if (gidx_q == LAST_IDX)
      rr_next = '0;
    else
      rr_next = gidx_q + IDX_WIDTH'(1);
`endif
    search_reqs = bus.req_sends & ~(complete ? gmask : '0);
    search_base = complete ? rr_next : rr_ptr;
  end

  always_comb begin
    int unsigned b;
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    b     = 32'(search_base);
    idx   = 0;
`ifdef UARC_ARB_PRIO0_EN
    if (search_reqs[0]) begin
      found = 1'b1;
    end else begin
      for (int unsigned i = 0; i < REQUESTERS - 1; i++) begin
        idx = 1 + (b - 1 + i) % (REQUESTERS - 1);
        if (!found && search_reqs[idx]) begin
          found = 1'b1;
          pick  = idx[IDX_WIDTH-1:0];
        end
      end
    end
`else
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      idx = (b + i) % REQUESTERS;
      if (!found && search_reqs[idx]) begin
        found = 1'b1;
        pick  = idx[IDX_WIDTH-1:0];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (found) state_next = BUSY;
      BUSY:    if (complete && !found) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.out_send      = (state == BUSY);
    bus.req_send_acks = complete ? gmask : '0;
  end

  assign load = found && ((state == IDLE) || complete);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      gidx_q <= '0;
      rr_ptr <= PTR_RST;
    end else begin
      if (load) begin
        data_q <= bus.req_datas[32'(pick)*WORD_WIDTH +: WORD_WIDTH];
        gidx_q <= pick;
      end
      if (complete)
        rr_ptr <= rr_next;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.grant_idx = gidx_q;
endmodule

// File: tb/tb_uarc_send_arbiter.sv
// Directed bench for uarc_send_arbiter: literal checks per scenario plus a
// grant-order model compared against the DUT every cycle.
module tb_uarc_send_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uarc_send_arbiter_if #(.WORD_WIDTH(W), .REQUESTERS(N)) bus();
  uarc_send_arbiter #(.WORD_MAG(5), .REQUESTERS(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [W-1:0] data [N];
  always_comb begin
    bus.req_datas = '0;
    for (int i = 0; i < N; i++) bus.req_datas[i*W +: W] = data[i];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: the winner is the first requester met walking the ring from the pointer.
  function automatic int model_pick(input logic [N-1:0] avail, input int ptr);
`ifdef UARC_ARB_PRIO0_EN
    if (avail[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      int cand = 1 + ((ptr - 1 + k) % (N - 1));
      if (avail[cand]) return cand;
    end
`else
    for (int k = 0; k < N; k++) begin
      int cand = (ptr + k) % N;
      if (avail[cand]) return cand;
    end
`endif
    return -1;
  endfunction

`ifdef UARC_ARB_PRIO0_EN
  localparam int PTR0 = 1;
`else
  localparam int PTR0 = 0;
`endif

  bit          m_valid = 1'b0;
  bit          m_busy  = 1'b0;
  int          m_g     = 0;
  int          m_ptr   = 0;
  logic [W-1:0] m_data = '0;

  always @(negedge clk) begin
    bit          done;
    logic [N-1:0] avail;
    int          w;
    done = m_busy && bus.out_send_ack && !reset;
    if (m_valid) begin
      chk("model_out_send", 32'(bus.out_send), 32'(m_busy));
      chk("model_acks", 32'(bus.req_send_acks), done ? (32'd1 << m_g) : 32'd0);
      if (m_busy) begin
        chk("model_grant_idx", 32'(bus.grant_idx), 32'(m_g));
        chk("model_out_data", bus.out_data, m_data);
      end
    end
    if (reset) begin
      m_valid = 1'b1;
      m_busy  = 1'b0;
      m_g     = 0;
      m_data  = '0;
      m_ptr   = PTR0;
    end else if (m_valid) begin
      avail = bus.req_sends;
      if (done) begin
        avail[m_g] = 1'b0;
`ifdef UARC_ARB_PRIO0_EN
        if (m_g != 0) m_ptr = (m_g == N - 1) ? 1 : m_g + 1;
`else
        m_ptr = (m_g + 1) % N;
`endif
      end
      if (!m_busy || done) begin
        w = model_pick(avail, m_ptr);
        if (w >= 0) begin
          m_busy = 1'b1;
          m_g    = w;
          m_data = data[w];
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_order [6];

  initial begin
`ifdef UARC_ARB_PRIO0_EN
    exp_order = '{0, 1, 0, 2, 0, 3};
`else
    exp_order = '{0, 1, 2, 3, 0, 1};
`endif
    for (int i = 0; i < N; i++) data[i] = 32'hA000_0000 + 32'(i);
    bus.req_sends    = 4'b1111;
    bus.out_send_ack = 1'b0;

    chk("pin_model_ring", 32'(model_pick(4'b1010, 2)), 32'd3);
    chk("pin_model_wrap", 32'(model_pick(4'b0011, 3)), 32'd0);

    // reset held with all requesting
    step(); step();
    @(negedge clk);
    chk("rst_out_send", 32'(bus.out_send), 32'd0);
    chk("rst_acks", 32'(bus.req_send_acks), 32'd0);
    chk("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("rel_out_send", 32'(bus.out_send), 32'd1);
    chk("rel_out_data", bus.out_data, 32'hA000_0000);
    step();
    bus.req_sends    = 4'b0000;
    bus.out_send_ack = 1'b1;
    step();
    bus.out_send_ack = 1'b0;

    // single requester, ack after 3 cycles, data change ignored while busy
    bus.req_sends = 4'b0100;
    data[2] = 32'hDEAD_BEEF;
    step();
    @(negedge clk);
    chk("single_grant", 32'(bus.grant_idx), 32'd2);
    chk("single_data0", bus.out_data, 32'hDEAD_BEEF);
    step();
    data[2] = 32'h0;
    @(negedge clk);
    chk("single_data1", bus.out_data, 32'hDEAD_BEEF);
    step();
    @(negedge clk);
    chk("single_data2", bus.out_data, 32'hDEAD_BEEF);
    chk("single_noack", 32'(bus.req_send_acks), 32'd0);
    step();
    bus.out_send_ack = 1'b1;
    @(negedge clk);
    chk("single_ack", 32'(bus.req_send_acks), 32'b0100);
    step();
    bus.req_sends    = 4'b0000;
    bus.out_send_ack = 1'b0;
    data[2] = 32'hA000_0002;
    @(negedge clk);
    chk("single_idle", 32'(bus.out_send), 32'd0);

    // stray ack while idle
    step();
    bus.out_send_ack = 1'b1;
    @(negedge clk);
    chk("stray_acks", 32'(bus.req_send_acks), 32'd0);
    chk("stray_idle0", 32'(bus.out_send), 32'd0);
    step();
    @(negedge clk);
    chk("stray_idle1", 32'(bus.out_send), 32'd0);
    step();
    bus.out_send_ack = 1'b0;

    // all requesting, ack tied high
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_sends    = 4'b1111;
    bus.out_send_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clk);
      chk($sformatf("rr_grant%0d", k), 32'(bus.grant_idx), 32'(exp_order[k]));
      chk($sformatf("rr_ack%0d", k), 32'(bus.req_send_acks), 32'd1 << exp_order[k]);
      chk($sformatf("rr_send%0d", k), 32'(bus.out_send), 32'd1);
    end
    step();
    bus.req_sends = 4'b0000;
    step();
    bus.out_send_ack = 1'b0;

    // reset mid-transfer coinciding with ack
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.req_sends = 4'b0010;
    step();
    reset = 1'b1;
    bus.out_send_ack = 1'b1;
    bus.req_sends = 4'b0011;
    @(negedge clk);
    chk("midrst_grant", 32'(bus.grant_idx), 32'd1);
    chk("midrst_noack", 32'(bus.req_send_acks), 32'd0);
    step();
    reset = 1'b0;
    bus.out_send_ack = 1'b0;
    @(negedge clk);
    chk("midrst_send0", 32'(bus.out_send), 32'd0);
    step();
    @(negedge clk);
    chk("midrst_regrant", 32'(bus.grant_idx), 32'd0);
    chk("midrst_send1", 32'(bus.out_send), 32'd1);
    chk("midrst_data", bus.out_data, 32'hA000_0000);
    step();
    bus.req_sends    = 4'b0000;
    bus.out_send_ack = 1'b1;
    step();
    bus.out_send_ack = 1'b0;
    step();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
